// File: rtl/mem_wb_unit_pkg.sv
// Shared pipeline constants and stage-register layouts for the memory and
// writeback stages.
package mem_wb_unit_pkg;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_write;
        logic [1:0]  src;
    } m_stage_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        reg_write;
        logic [1:0]  src;
    } w_stage_t;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result select: ALU result, load data or return address.
module wb_result_mux
    import mem_wb_unit_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [31:0] alu,
    input  logic [31:0] rdata,
    input  logic [31:0] pc4,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (sel)
            SRC_ALU:  result = alu;
            SRC_LOAD: result = rdata;
            SRC_PC4:  result = pc4;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_unit.sv
// Memory + writeback pipeline stages with a stalling data-memory handshake
// and a bounded wait that aborts the access and raises a sticky bus error.
module mem_wb_unit
    import mem_wb_unit_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [31:0] PCplus4E,
    input  logic [4:0]  RdE,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic [1:0]  ResultSrcE,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] ALUResultM,
    output logic [4:0]  RdM,
    output logic        RegWriteM,
    output logic [31:0] ResultW,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic        stallM,
    output logic        bus_err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    m_stage_t   e_in, m_d, m_q;
    w_stage_t   w_d, w_q;
    mem_state_e state_d, state_q;
    logic [7:0] cnt_d, cnt_q;
    logic       bus_err_d, bus_err_q;
    logic       memop_m, is_load_m, timeout;

    assign e_in = '{alu: ALUResultE, wdata: WriteDataE, pc4: PCplus4E, rd: RdE,
                    reg_write: RegWriteE, mem_write: MemWriteE, src: ResultSrcE};

    assign is_load_m  = (m_q.src == SRC_LOAD);
    assign memop_m    = m_q.mem_write | is_load_m;
    assign dmem_req   = memop_m;
    assign dmem_we    = m_q.mem_write;
    assign dmem_addr  = m_q.alu;
    assign dmem_wdata = m_q.wdata;

    // cnt_q counts request cycles already spent, so the first WAIT cycle sees 1.
    assign timeout = (state_q == ST_WAIT) && (cnt_q == TMO_LAST) && !dmem_ack;
    assign stallM  = dmem_req & ~dmem_ack & ~timeout;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (dmem_req && !dmem_ack) state_d = ST_WAIT;
            ST_WAIT: if (!dmem_req || dmem_ack || timeout) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        cnt_d     = (state_d == ST_WAIT) ? cnt_q + 8'd1 : 8'd0;
        bus_err_d = bus_err_q | timeout;
        m_d       = stallM ? m_q : e_in;

        w_d = '0;
        if (!stallM) begin
            w_d.alu       = m_q.alu;
            w_d.pc4       = m_q.pc4;
            w_d.rd        = m_q.rd;
            w_d.src       = m_q.src;
            // Stores and aborted accesses never write the register file.
            w_d.reg_write = m_q.reg_write & ~m_q.mem_write & ~timeout;
            w_d.rdata     = (is_load_m && dmem_ack) ? dmem_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            m_q       <= '0;
            w_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            m_q       <= m_d;
            w_q       <= w_d;
        end
    end

    wb_result_mux u_wb_mux (
        .sel    (w_q.src),
        .alu    (w_q.alu),
        .rdata  (w_q.rdata),
        .pc4    (w_q.pc4),
        .result (ResultW)
    );

    assign ALUResultM = m_q.alu;
    assign RdM        = m_q.rd;
    assign RegWriteM  = m_q.reg_write;
    assign RdW        = w_q.rd;
    assign RegWriteW  = w_q.reg_write;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_wb_unit.sv
// Scoreboard bench for mem_wb_unit: directed ops push expected W results,
// a negedge monitor pops and compares whenever a non-bubble reaches W.
module tb_mem_wb_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ALUResultE = '0, WriteDataE = '0, PCplus4E = '0;
    logic [4:0]  RdE = '0;
    logic        RegWriteE = 1'b0, MemWriteE = 1'b0;
    logic [1:0]  ResultSrcE = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] ALUResultM, ResultW;
    logic [4:0]  RdM, RdW;
    logic        RegWriteM, RegWriteW, stallM, bus_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;
    exp_t sb[$];

    mem_wb_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCplus4E(PCplus4E),
        .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
        .stallM(stallM), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [4:0] rd, input logic rw, input logic mw, input logic [1:0] src);
        ALUResultE = alu; WriteDataE = wd; PCplus4E = pc4;
        RdE = rd; RegWriteE = rw; MemWriteE = mw; ResultSrcE = src;
    endtask

    task automatic nop();
        drive(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic push(input logic [31:0] r, input logic [4:0] rd, input logic rw);
        exp_t e;
        e.result = r; e.rd = rd; e.rw = rw;
        sb.push_back(e);
    endtask

    // Monitor: every non-bubble W entry (RdW != 0) must match the queue head.
    always @(negedge clk) begin
        if (reset && RdW != 5'd0) begin
            if (sb.size() == 0) begin
                chk("unexpected_w_rd", {27'd0, RdW}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("w_result", ResultW, e.result);
                chk("w_rd", {27'd0, RdW}, {27'd0, e.rd});
                chk("w_regwrite", {31'd0, RegWriteW}, {31'd0, e.rw});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        tick(); tick();
        chk("rst_resultw", ResultW, 32'd0);
        chk("rst_regwritew", {31'd0, RegWriteW}, 32'd0);
        chk("rst_regwritem", {31'd0, RegWriteM}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stallM}, 32'd0);
        chk("rst_buserr", {31'd0, bus_err}, 32'd0);
        reset = 1'b1;
        tick();

        // ALU op
        drive(32'h0000_1234, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 2'b00);
        push(32'h0000_1234, 5'd5, 1'b1);
        tick();
        chk("alu_m_result", ALUResultM, 32'h0000_1234);
        chk("alu_m_rd", {27'd0, RdM}, 32'd5);
        chk("alu_m_rw", {31'd0, RegWriteM}, 32'd1);
        chk("alu_stall", {31'd0, stallM}, 32'd0);
        // Back-to-back ALU ops, second with RegWrite off
        drive(32'h0000_AAAA, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 2'b00);
        push(32'h0000_AAAA, 5'd3, 1'b1);
        tick();
        chk("alu2_stall", {31'd0, stallM}, 32'd0);
        drive(32'h0000_5555, 32'd0, 32'd0, 5'd4, 1'b0, 1'b0, 2'b00);
        push(32'h0000_5555, 5'd4, 1'b0);
        tick();
        nop();
        tick(); tick();

        // Zero-wait load
        drive(32'h0000_0100, 32'd0, 32'd0, 5'd7, 1'b1, 1'b0, 2'b01);
        push(32'hDEAD_BEEF, 5'd7, 1'b1);
        tick();
        nop();
        chk("ld_req", {31'd0, dmem_req}, 32'd1);
        chk("ld_we", {31'd0, dmem_we}, 32'd0);
        chk("ld_addr", dmem_addr, 32'h0000_0100);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_stall", {31'd0, stallM}, 32'd0);
        tick();
        dmem_ack = 1'b0; dmem_rdata = '0;
        tick();

        // Store with 3 wait cycles
        drive(32'h0000_0200, 32'h0000_0055, 32'd0, 5'd9, 1'b1, 1'b1, 2'b00);
        push(32'h0000_0200, 5'd9, 1'b0);
        tick();
        nop();
        chk("st_we", {31'd0, dmem_we}, 32'd1);
        chk("st_wdata", dmem_wdata, 32'h0000_0055);
        chk("st_addr", dmem_addr, 32'h0000_0200);
        for (int i = 0; i < 3; i++) begin
            chk("st_stall", {31'd0, stallM}, 32'd1);
            chk("st_regwritew", {31'd0, RegWriteW}, 32'd0);
            tick();
        end
        dmem_ack = 1'b1;
        #1;
        chk("st_ack_stall", {31'd0, stallM}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        // Stray ack with no request outstanding
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("stray_ack_stall", {31'd0, stallM}, 32'd0);
        tick();
        dmem_ack = 1'b0;

        // JAL-type op
        drive(32'h0000_0999, 32'd0, 32'h0000_0044, 5'd1, 1'b1, 1'b0, 2'b10);
        push(32'h0000_0044, 5'd1, 1'b1);
        tick();
        nop();
        tick(); tick();

        // Load that never gets an ack
        drive(32'h0000_0300, 32'd0, 32'd0, 5'd10, 1'b1, 1'b0, 2'b01);
        push(32'd0, 5'd10, 1'b0);
        tick();
        nop();
        n = 0;
        while (stallM && n < 40) begin
            n++;
            tick();
        end
        chk("tmo_stall_cycles", n, 32'd14);
        chk("tmo_buserr_before", {31'd0, bus_err}, 32'd0);
        tick();
        chk("tmo_buserr_set", {31'd0, bus_err}, 32'd1);
        chk("tmo_stall_after", {31'd0, stallM}, 32'd0);
        tick(); tick(); tick();
        chk("tmo_buserr_sticky", {31'd0, bus_err}, 32'd1);

        // Reset in the middle of a WAIT, then a late ack
        drive(32'h0000_0400, 32'd0, 32'd0, 5'd11, 1'b1, 1'b0, 2'b01);
        tick();
        nop();
        tick(); tick();
        chk("rw_stall_pre", {31'd0, stallM}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rw_req_rst", {31'd0, dmem_req}, 32'd0);
        chk("rw_stall_rst", {31'd0, stallM}, 32'd0);
        chk("rw_buserr_rst", {31'd0, bus_err}, 32'd0);
        chk("rw_regwritew_rst", {31'd0, RegWriteW}, 32'd0);
        tick();
        reset = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("rw_req_after", {31'd0, dmem_req}, 32'd0);
        chk("rw_stall_after", {31'd0, stallM}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("rw_regwritew_after", {31'd0, RegWriteW}, 32'd0);
        chk("rw_buserr_after", {31'd0, bus_err}, 32'd0);

        // A plain op still flows after the aborted access
        drive(32'h0000_0777, 32'd0, 32'd0, 5'd12, 1'b1, 1'b0, 2'b00);
        push(32'h0000_0777, 5'd12, 1'b1);
        tick();
        nop();
        tick(); tick(); tick();

        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_unit.md
MEM_WB_UNIT -- requirements
Module: mem_wb_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, 15, max wait cycles for dmem_ack before abort (legal 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ALUResultE, WriteDataE, PCplus4E  input  32 each  execute-stage results.
REQ-005 SHALL have ports RdE  input  5, RegWriteE  input  1, MemWriteE  input  1, ResultSrcE  input  2  (00 ALU, 01 load, 10 PC+4).
REQ-006 SHALL have ports dmem_req  output  1, dmem_we  output  1, dmem_addr  output  32, dmem_wdata  output  32  data-memory request.
REQ-007 SHALL have ports dmem_rdata  input  32, dmem_ack  input  1  data-memory response.
REQ-008 SHALL have ports ALUResultM  output  32, RdM  output  5, RegWriteM  output  1  forwarding source, memory stage.
REQ-009 SHALL have ports ResultW  output  32, RdW  output  5, RegWriteW  output  1  writeback result and forwarding source.
REQ-010 SHALL have ports stallM  output  1 (freeze upstream stages), bus_err  output  1 (sticky timeout flag).

Function
REQ-011 M register SHALL capture all E-side inputs on each rising edge where stallM=0, and hold when stallM=1.
REQ-012 memopM SHALL be MemWriteM | (ResultSrcM==01); dmem_addr=ALUResultM, dmem_wdata=WriteDataM, dmem_we=MemWriteM, combinationally.
REQ-013 FSM states SHALL be IDLE and WAIT; dmem_req=1 whenever memopM=1 and state is IDLE or WAIT, else 0.
REQ-014 IDLE->WAIT SHALL occur when dmem_req=1 and dmem_ack=0; WAIT->IDLE on dmem_ack=1 or timeout; IDLE->IDLE when ack arrives same cycle as req (zero-wait access).
REQ-015 stallM SHALL equal dmem_req & ~dmem_ack & ~timeout, combinationally.
REQ-016 Wait counter (8 bits) SHALL clear in IDLE and increment each WAIT cycle; timeout=1 when in WAIT and count==TIMEOUT-1 and dmem_ack=0.
REQ-017 On timeout, bus_err SHALL set on the next edge and stay 1 until reset; the aborted op SHALL enter W with RegWriteW=0 and ReadDataW=0.
REQ-018 ReadDataW SHALL capture dmem_rdata on the edge where dmem_ack=1 for a load.
REQ-019 W register SHALL capture M fields on each edge with stallM=0; with stallM=1 it SHALL load a bubble (RegWriteW=0, RdW=0).
REQ-020 ResultW SHALL be ALUResultW (00), ReadDataW (01), PCplus4W (10), 0 (11).
REQ-021 Latency: non-memory op SHALL reach W exactly 1 cycle after entering M; memory op 1+N cycles where N = ack wait cycles.
REQ-022 dmem_ack while dmem_req=0 SHALL be ignored.
REQ-023 Stores SHALL never produce RegWriteW=1 regardless of RegWriteE.

Reset
REQ-024 While reset=0: all M/W registers 0, ResultW=0, RegWriteM=RegWriteW=0, FSM IDLE, counter 0, bus_err 0, dmem_req=0, stallM=0.
REQ-025 Reset asserted mid-WAIT SHALL abandon the access immediately; a later dmem_ack SHALL be ignored per REQ-022.

Structure
REQ-026 ResultSrc encodings and FSM state encodings SHALL be constants in the shared pipeline package.
REQ-027 The W-stage result mux SHALL be a separate sub-module wb_result_mux; all else in mem_wb_unit.

Verification
REQ-028 ALU op ALUResultE=0x0000_1234, RdE=5, RegWriteE=1 -> next cycle ALUResultM=0x1234, RdM=5; following cycle ResultW=0x1234, RegWriteW=1, stallM never 1.
REQ-029 Load addr 0x100, ack same cycle, dmem_rdata=0xDEAD_BEEF -> stallM=0, next cycle ResultW=0xDEADBEEF, RdW as issued.
REQ-030 Store addr 0x200, WriteDataE=0x55, ack after 3 cycles -> dmem_we=1, dmem_wdata=0x55, stallM=1 for 3 cycles, RegWriteW=0 throughout.
REQ-031 Load, ack never arrives, TIMEOUT=15 -> stallM high 14 cycles then drops, bus_err=1 next edge and stays, RegWriteW=0.
REQ-032 Load in WAIT for 2 cycles, reset pulsed low, then ack -> after reset dmem_req=0, state IDLE, RegWriteW=0, bus_err=0.
REQ-033 JAL-type op ResultSrcE=10, PCplus4E=0x44 -> ResultW=0x44 two cycles later.
